pifo_multi_port_core: RTL and testbench
=======================================

Name: pifo_multi_port_core

Overview:
- Parametrised successor to the root-only scheduler PIFO: one independent sorted PIFO per output port, so ranks are no longer serialised through a single root queue.
- Sits between the enqueue agent and the per-port dequeue FSMs.
  - Enqueue agent supplies rank and buffer pointer, taken from the tpifo word {valid, rank[18:0], ptr[11:0]}.
  - Each dequeue FSM pops its port's lowest-rank descriptor and then reads the packet buffer.
- Adds full-queue policy selection and a drop-report channel so the buffer manager can free pointers.

Parameters:
- NUM_PORTS, 5, number of output ports (one PIFO each).
- DEPTH, 16, entries per port PIFO (>=2).
- RANK_WIDTH, 19, rank bits; lower value = higher priority.
- PTR_WIDTH, 12, buffer descriptor pointer bits.
- FULL_POLICY, 0, 0 = tail-drop the arriving entry; 1 = push-out the worst-ranked entry.
- PORT_W, $clog2(NUM_PORTS), push_port width.
- CNT_W, $clog2(DEPTH+1), occupancy width.

Ports:
- axis_aclk  in  1  clock.
- axis_reset  in  1  asynchronous active-high reset.
- push_en  in  1  insert request, single-cycle qualified.
- push_port  in  PORT_W  target port.
- push_rank  in  RANK_WIDTH  rank of the arriving descriptor.
- push_ptr  in  PTR_WIDTH  buffer pointer of the arriving descriptor.
- pop_req  in  NUM_PORTS  per-port pop; consumes the head when the same port's head_valid is 1.
- head_valid  out  NUM_PORTS  port PIFO non-empty.
- head_rank  out  NUM_PORTS*RANK_WIDTH  per-port head rank, show-ahead; port p at [p*RANK_WIDTH +: RANK_WIDTH].
- head_ptr  out  NUM_PORTS*PTR_WIDTH  per-port head pointer, show-ahead.
- occupancy  out  NUM_PORTS*CNT_W  per-port entry count.
- drop_valid  out  1  one-cycle pulse: a pointer was discarded.
- drop_ptr  out  PTR_WIDTH  the discarded pointer.
- drop_count  out  32  saturating count of all drops.

Behaviour:
- Reset (async, active-high): all entries invalid; head_valid=0; head_rank=0; head_ptr=0; occupancy=0; drop_valid=0; drop_ptr=0; drop_count=0. Reset asserted mid-operation discards all contents immediately; no drop is reported for them.
- Storage:
  - Per port, a shift-register sorted array; entry 0 is the head.
  - Order is ascending rank.
  - Equal ranks keep FIFO order: a new entry is inserted after all existing entries of equal rank.
- Latency:
  - A push is visible on head_*/occupancy the cycle after push_en.
  - A pop updates the head the cycle after pop_req.
  - All outputs are registered.
- Pop:
  - pop_req[p] with head_valid[p]=0 is ignored.
  - Otherwise the array shifts toward the head and occupancy decrements.
- Push and pop on the same port in the same cycle:
  - The current head is removed first.
  - The new entry is inserted into the shifted array; occupancy is unchanged.
  - The new entry may become the head the next cycle.
- Push to an empty port with a simultaneous pop on that port: the pop is ignored; the push is inserted.
- Full port (occupancy=DEPTH) with no same-cycle pop:
  - FULL_POLICY=0: the arriving entry is dropped; drop_ptr=push_ptr.
  - FULL_POLICY=1, push_rank < tail rank: the tail entry is evicted and drop_ptr=tail ptr; the new entry is inserted.
  - FULL_POLICY=1, push_rank >= tail rank: the arriving entry is dropped.
- Full port with a same-cycle pop: no drop; the insert proceeds.
- push_port >= NUM_PORTS: the arriving entry is dropped; drop_ptr=push_ptr.
- On every drop:
  - drop_valid pulses for exactly one cycle, the cycle after the push.
  - drop_count increments, saturating at 32'hFFFFFFFF.
- At most one push per cycle, so at most one drop per cycle.
- Ports are fully independent: pops on different ports in the same cycle are all honoured.

Decomposition:
- Shared include/package pifo_defs holds:
  - the tpifo field offsets (valid bit 31, rank [30:12], ptr [11:0]);
  - the FULL_POLICY encodings POLICY_TAIL_DROP=0 and POLICY_PUSH_OUT=1;
  - the entry layout {rank, ptr} as localparams.
- Sub-module pifo_sorted_array:
  - one per port, generate-instantiated;
  - parameters DEPTH/RANK_WIDTH/PTR_WIDTH/FULL_POLICY;
  - owns compare vector, insert/shift logic, head, occupancy and the evict/drop decision.
- The top level owns:
  - push_port decode;
  - drop arbitration (a single active push means a single source);
  - drop_valid/drop_ptr/drop_count registers.

Test Plan:
- Single-entry round trip: reset, push port0 rank 100 ptr 0x01 -> next cycle head_valid[0]=1, head_rank=100, head_ptr=0x01, occupancy[0]=1; pop -> head_valid[0]=0 next cycle.
- Ordering: push port0 (50,0x04) then (10,0x05) -> head ptr 0x05; after pop, head ptr 0x04; equal-rank pushes (20,0xA),(20,0xB) pop in order A then B.
- Simultaneous push and pop: port0 holds (50,0x06); same cycle pop and push (10,0x07) -> next cycle occupancy=1, head=(10,0x07); 0x06 gone, no drop.
- Full with FULL_POLICY=0, DEPTH=4: fill ranks 10,20,30,40, push (5,0x99) -> drop_valid=1, drop_ptr=0x99, drop_count=1, head stays rank 10.
- Full with FULL_POLICY=1, DEPTH=4:
  - Same fill, push (5,0x99) -> drop_ptr = ptr of the rank-40 entry; head=(5,0x99).
  - Then push (50,0x98) -> drop_ptr=0x98.
- Independence and reset:
  - Push ports 0 and 3, pop both in the same cycle -> both heads clear.
  - Assert axis_reset while 3 entries are queued -> all outputs 0 immediately, no drop_valid.
  - push_port=7 with NUM_PORTS=5 -> dropped, drop_ptr=push_ptr.

Source files
------------

// File: rtl/pifo_multi_port_core_pkg.sv
// Shared definitions for the multi-port PIFO: tpifo word layout, full-queue policies
// and the {rank, ptr} entry layout.
package pifo_multi_port_core_pkg;

  localparam int unsigned TPIFO_VALID_BIT = 31;
  localparam int unsigned TPIFO_RANK_MSB  = 30;
  localparam int unsigned TPIFO_RANK_LSB  = 12;
  localparam int unsigned TPIFO_PTR_MSB   = 11;
  localparam int unsigned TPIFO_PTR_LSB   = 0;

  localparam int unsigned POLICY_TAIL_DROP = 0;
  localparam int unsigned POLICY_PUSH_OUT  = 1;

  localparam int unsigned DEF_RANK_WIDTH = 19;
  localparam int unsigned DEF_PTR_WIDTH  = 12;
  localparam int unsigned ENTRY_PTR_LSB  = 0;
  localparam int unsigned ENTRY_RANK_LSB = DEF_PTR_WIDTH;
  localparam int unsigned ENTRY_W        = DEF_RANK_WIDTH + DEF_PTR_WIDTH;

  typedef struct packed {
    logic                      valid;
    logic [DEF_RANK_WIDTH-1:0] rank;
    logic [DEF_PTR_WIDTH-1:0]  ptr;
  } tpifo_word_t;

endpackage

// File: rtl/pifo_multi_port_core_if.sv
// Push/pop/head/drop bundle between the enqueue agent, dequeue FSMs and the PIFO core.
interface pifo_multi_port_core_if #(
  parameter int unsigned NUM_PORTS  = 5,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned RANK_WIDTH = 19,
  parameter int unsigned PTR_WIDTH  = 12,
  parameter int unsigned PORT_W     = $clog2(NUM_PORTS),
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
);
  logic                            push_en;
  logic [PORT_W-1:0]               push_port;
  logic [RANK_WIDTH-1:0]           push_rank;
  logic [PTR_WIDTH-1:0]            push_ptr;
  logic [NUM_PORTS-1:0]            pop_req;
  logic [NUM_PORTS-1:0]            head_valid;
  logic [NUM_PORTS*RANK_WIDTH-1:0] head_rank;
  logic [NUM_PORTS*PTR_WIDTH-1:0]  head_ptr;
  logic [NUM_PORTS*CNT_W-1:0]      occupancy;
  logic                            drop_valid;
  logic [PTR_WIDTH-1:0]            drop_ptr;
  logic [31:0]                     drop_count;

  modport master (
    output push_en, push_port, push_rank, push_ptr, pop_req,
    input  head_valid, head_rank, head_ptr, occupancy, drop_valid, drop_ptr, drop_count
  );

  modport slave (
    input  push_en, push_port, push_rank, push_ptr, pop_req,
    output head_valid, head_rank, head_ptr, occupancy, drop_valid, drop_ptr, drop_count
  );
endinterface

// File: rtl/pifo_multi_port_core_sorted_array.sv
// One port's sorted shift-register PIFO: pop-then-insert, FIFO order among equal ranks,
// and the tail-drop / push-out decision when full.
module pifo_sorted_array
  import pifo_multi_port_core_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned RANK_WIDTH  = 19,
  parameter int unsigned PTR_WIDTH   = 12,
  parameter int unsigned FULL_POLICY = POLICY_TAIL_DROP,
  parameter int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [RANK_WIDTH-1:0] i_rank,
  input  logic [PTR_WIDTH-1:0]  i_ptr,
  output logic                  o_head_valid,
  output logic [RANK_WIDTH-1:0] o_head_rank,
  output logic [PTR_WIDTH-1:0]  o_head_ptr,
  output logic [CNT_W-1:0]      o_occupancy,
  output logic                  o_drop_c,
  output logic [PTR_WIDTH-1:0]  o_drop_ptr_c
);

  logic [DEPTH-1:0]      r_valid;
  logic [RANK_WIDTH-1:0] r_rank [DEPTH];
  logic [PTR_WIDTH-1:0]  r_ptr  [DEPTH];
  logic [CNT_W-1:0]      r_cnt;

  logic [DEPTH-1:0]      w_s_valid, w_n_valid, w_ge;
  logic [RANK_WIDTH-1:0] w_s_rank [DEPTH];
  logic [RANK_WIDTH-1:0] w_n_rank [DEPTH];
  logic [PTR_WIDTH-1:0]  w_s_ptr  [DEPTH];
  logic [PTR_WIDTH-1:0]  w_n_ptr  [DEPTH];
  logic [CNT_W-1:0]      w_s_cnt, w_n_cnt;
  logic                  w_do_pop, w_full, w_ins;
  logic                  w_prev_ge, w_prev_valid;
  logic [RANK_WIDTH-1:0] w_prev_rank;
  logic [PTR_WIDTH-1:0]  w_prev_ptr;

  // Head removal happens first; the insert then works on the shifted array.
  always_comb begin
    w_do_pop  = i_pop && r_valid[0];
    w_s_valid = r_valid;
    w_s_rank  = r_rank;
    w_s_ptr   = r_ptr;
    if (w_do_pop) begin
      w_s_valid = {1'b0, r_valid[DEPTH-1:1]};
      for (int i = 0; i < DEPTH - 1; i++) begin
        w_s_rank[i] = r_rank[i+1];
        w_s_ptr[i]  = r_ptr[i+1];
      end
      w_s_rank[DEPTH-1] = '0;
      w_s_ptr[DEPTH-1]  = '0;
    end
    w_s_cnt = r_cnt - CNT_W'(w_do_pop);
  end

  // w_ge marks entries that stay ahead of the new one (rank <= push rank keeps FIFO ties).
  always_comb begin
    w_full = (w_s_cnt == CNT_W'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      w_ge[i] = w_s_valid[i] && (w_s_rank[i] <= i_rank);
    end
    w_ins = i_push && (!w_full ||
                       ((FULL_POLICY == POLICY_PUSH_OUT) && !w_ge[DEPTH-1]));
    o_drop_c     = i_push && w_full;
    o_drop_ptr_c = w_ins ? w_s_ptr[DEPTH-1] : i_ptr;
    w_n_cnt      = w_s_cnt + CNT_W'(w_ins && !w_full);

    w_n_valid    = w_s_valid;
    w_n_rank     = w_s_rank;
    w_n_ptr      = w_s_ptr;
    w_prev_ge    = 1'b1;
    w_prev_valid = 1'b0;
    w_prev_rank  = '0;
    w_prev_ptr   = '0;
    if (w_ins) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!w_ge[i]) begin
          if (w_prev_ge) begin
            w_n_valid[i] = 1'b1;
            w_n_rank[i]  = i_rank;
            w_n_ptr[i]   = i_ptr;
          end else begin
            w_n_valid[i] = w_prev_valid;
            w_n_rank[i]  = w_prev_rank;
            w_n_ptr[i]   = w_prev_ptr;
          end
        end
        w_prev_ge    = w_ge[i];
        w_prev_valid = w_s_valid[i];
        w_prev_rank  = w_s_rank[i];
        w_prev_ptr   = w_s_ptr[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rank[i] <= '0;
        r_ptr[i]  <= '0;
      end
    end else begin
      r_valid <= w_n_valid;
      r_cnt   <= w_n_cnt;
      for (int i = 0; i < DEPTH; i++) begin
        r_rank[i] <= w_n_rank[i];
        r_ptr[i]  <= w_n_ptr[i];
      end
    end
  end

  assign o_head_valid = r_valid[0];
  assign o_head_rank  = r_rank[0];
  assign o_head_ptr   = r_ptr[0];
  assign o_occupancy  = r_cnt;

endmodule

// File: rtl/pifo_multi_port_core.sv
// Multi-port PIFO: one sorted array per output port, push_port decode, and a single
// registered drop-report channel with a saturating drop counter.
module pifo_multi_port_core
  import pifo_multi_port_core_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 5,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned RANK_WIDTH  = 19,
  parameter int unsigned PTR_WIDTH   = 12,
  parameter int unsigned FULL_POLICY = POLICY_TAIL_DROP,
  parameter int unsigned PORT_W      = $clog2(NUM_PORTS),
  parameter int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
  input logic                    axis_aclk,
  input logic                    axis_reset,
  pifo_multi_port_core_if.slave  bus
);

  logic                  w_head_valid [NUM_PORTS];
  logic [RANK_WIDTH-1:0] w_head_rank  [NUM_PORTS];
  logic [PTR_WIDTH-1:0]  w_head_ptr   [NUM_PORTS];
  logic [CNT_W-1:0]      w_occ        [NUM_PORTS];
  logic                  w_port_drop  [NUM_PORTS];
  logic [PTR_WIDTH-1:0]  w_port_dptr  [NUM_PORTS];

  logic                  w_bad_port, w_drop;
  logic [PTR_WIDTH-1:0]  w_drop_ptr;
  logic                  r_drop_valid;
  logic [PTR_WIDTH-1:0]  r_drop_ptr;
  logic [31:0]           r_drop_count;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic w_push;
    assign w_push = bus.push_en && (bus.push_port == PORT_W'(p));

    pifo_sorted_array #(
      .DEPTH(DEPTH), .RANK_WIDTH(RANK_WIDTH), .PTR_WIDTH(PTR_WIDTH),
      .FULL_POLICY(FULL_POLICY), .CNT_W(CNT_W)
    ) u_array (
      .clk(axis_aclk), .rst(axis_reset),
      .i_push(w_push), .i_pop(bus.pop_req[p]),
      .i_rank(bus.push_rank), .i_ptr(bus.push_ptr),
      .o_head_valid(w_head_valid[p]), .o_head_rank(w_head_rank[p]),
      .o_head_ptr(w_head_ptr[p]), .o_occupancy(w_occ[p]),
      .o_drop_c(w_port_drop[p]), .o_drop_ptr_c(w_port_dptr[p])
    );
  end

  always_comb begin
    bus.head_valid = '0;
    bus.head_rank  = '0;
    bus.head_ptr   = '0;
    bus.occupancy  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      bus.head_valid[p]                        = w_head_valid[p];
      bus.head_rank[p*RANK_WIDTH +: RANK_WIDTH] = w_head_rank[p];
      bus.head_ptr[p*PTR_WIDTH +: PTR_WIDTH]    = w_head_ptr[p];
      bus.occupancy[p*CNT_W +: CNT_W]           = w_occ[p];
    end
  end

  // Only one push per cycle, so at most one source can report a drop.
  always_comb begin
    w_bad_port = bus.push_en && (32'(bus.push_port) >= NUM_PORTS);
    w_drop     = w_bad_port;
    w_drop_ptr = bus.push_ptr;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_port_drop[p]) begin
        w_drop     = 1'b1;
        w_drop_ptr = w_port_dptr[p];
      end
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      r_drop_valid <= 1'b0;
      r_drop_ptr   <= '0;
      r_drop_count <= '0;
    end else begin
      r_drop_valid <= w_drop;
      if (w_drop) begin
        r_drop_ptr <= w_drop_ptr;
        if (r_drop_count != 32'hFFFF_FFFF) r_drop_count <= r_drop_count + 32'd1;
      end
    end
  end

  assign bus.drop_valid = r_drop_valid;
  assign bus.drop_ptr   = r_drop_ptr;
  assign bus.drop_count = r_drop_count;

endmodule

// File: tb/tb_pifo_multi_port_core.sv
// Drives a tail-drop and a push-out instance (DEPTH=4) with identical stimulus and
// compares both against queue-based reference models.
module tb_pifo_multi_port_core;
  localparam int unsigned NP = 5;
  localparam int unsigned DP = 4;
  localparam int unsigned RW = 19;
  localparam int unsigned PW = 12;
  localparam int unsigned PTW = 3;
  localparam int unsigned CW = 3;

  typedef struct packed {
    logic [RW-1:0] rank;
    logic [PW-1:0] ptr;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pifo_multi_port_core_if #(.NUM_PORTS(NP), .DEPTH(DP), .RANK_WIDTH(RW), .PTR_WIDTH(PW),
                            .PORT_W(PTW), .CNT_W(CW)) bus0 ();
  pifo_multi_port_core_if #(.NUM_PORTS(NP), .DEPTH(DP), .RANK_WIDTH(RW), .PTR_WIDTH(PW),
                            .PORT_W(PTW), .CNT_W(CW)) bus1 ();

  pifo_multi_port_core #(.NUM_PORTS(NP), .DEPTH(DP), .RANK_WIDTH(RW), .PTR_WIDTH(PW),
                         .FULL_POLICY(0), .PORT_W(PTW), .CNT_W(CW))
    dut0 (.axis_aclk(clk), .axis_reset(rst), .bus(bus0));
  pifo_multi_port_core #(.NUM_PORTS(NP), .DEPTH(DP), .RANK_WIDTH(RW), .PTR_WIDTH(PW),
                         .FULL_POLICY(1), .PORT_W(PTW), .CNT_W(CW))
    dut1 (.axis_aclk(clk), .axis_reset(rst), .bus(bus1));

  ent_t          mq [2][NP][$];
  logic          exp_dv [2];
  logic [PW-1:0] exp_dp [2];
  logic [31:0]   exp_dc [2];
  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [PTW-1:0] port, input logic [RW-1:0] rank,
                       input logic [PW-1:0] ptr, input logic [NP-1:0] pop);
    bus0.push_en = en; bus0.push_port = port; bus0.push_rank = rank;
    bus0.push_ptr = ptr; bus0.pop_req = pop;
    bus1.push_en = en; bus1.push_port = port; bus1.push_rank = rank;
    bus1.push_ptr = ptr; bus1.pop_req = pop;
  endtask

  task automatic model_drop(input int d, input logic [PW-1:0] ptr);
    exp_dv[d] = 1'b1;
    exp_dp[d] = ptr;
    if (exp_dc[d] != 32'hFFFF_FFFF) exp_dc[d]++;
  endtask

  task automatic model_insert(input int d, input int p, input ent_t e);
    int idx;
    idx = mq[d][p].size();
    for (int i = 0; i < mq[d][p].size(); i++) begin
      if (mq[d][p][i].rank > e.rank) begin
        idx = i;
        break;
      end
    end
    mq[d][p].insert(idx, e);
  endtask

  // Instance 0 is tail-drop, instance 1 is push-out.
  task automatic model_step(input int d, input logic en, input logic [PTW-1:0] port,
                            input logic [RW-1:0] rank, input logic [PW-1:0] ptr,
                            input logic [NP-1:0] pop);
    ent_t e;
    int   p;
    exp_dv[d] = 1'b0;
    for (int q = 0; q < NP; q++)
      if (pop[q] && mq[d][q].size() > 0) void'(mq[d][q].pop_front());
    if (en) begin
      e.rank = rank; e.ptr = ptr;
      p = int'(port);
      if (p >= NP) model_drop(d, ptr);
      else if (mq[d][p].size() == DP) begin
        if (d == 1 && rank < mq[d][p][DP-1].rank) begin
          model_drop(d, mq[d][p][DP-1].ptr);
          void'(mq[d][p].pop_back());
          model_insert(d, p, e);
        end else model_drop(d, ptr);
      end else model_insert(d, p, e);
    end
  endtask

  task automatic check_all(input int d, input logic [NP-1:0] hv, input logic [NP*RW-1:0] hr,
                           input logic [NP*PW-1:0] hp, input logic [NP*CW-1:0] occ,
                           input logic dv, input logic [PW-1:0] dp, input logic [31:0] dc);
    logic [NP-1:0]    e_hv;
    logic [NP*CW-1:0] e_occ;
    for (int p = 0; p < NP; p++) begin
      e_hv[p] = mq[d][p].size() != 0;
      e_occ[p*CW +: CW] = CW'(mq[d][p].size());
    end
    chk($sformatf("d%0d head_valid", d), 64'(hv), 64'(e_hv));
    chk($sformatf("d%0d occupancy", d), 64'(occ), 64'(e_occ));
    for (int p = 0; p < NP; p++)
      if (e_hv[p]) chk($sformatf("d%0d head p%0d", d, p),
                       64'({hr[p*RW +: RW], hp[p*PW +: PW]}), 64'(mq[d][p][0]));
    chk($sformatf("d%0d drop_valid", d), 64'(dv), 64'(exp_dv[d]));
    if (exp_dv[d]) chk($sformatf("d%0d drop_ptr", d), 64'(dp), 64'(exp_dp[d]));
    chk($sformatf("d%0d drop_count", d), 64'(dc), 64'(exp_dc[d]));
  endtask

  task automatic check_reset(input int d, input logic [NP-1:0] hv, input logic [NP*RW-1:0] hr,
                             input logic [NP*PW-1:0] hp, input logic [NP*CW-1:0] occ,
                             input logic dv, input logic [PW-1:0] dp, input logic [31:0] dc);
    chk($sformatf("d%0d rst head_valid", d), 64'(hv), 64'(0));
    chk($sformatf("d%0d rst occupancy", d), 64'(occ), 64'(0));
    for (int p = 0; p < NP; p++)
      chk($sformatf("d%0d rst head p%0d", d, p),
          64'({hr[p*RW +: RW], hp[p*PW +: PW]}), 64'(0));
    chk($sformatf("d%0d rst drop_valid", d), 64'(dv), 64'(0));
    chk($sformatf("d%0d rst drop_ptr", d), 64'(dp), 64'(0));
    chk($sformatf("d%0d rst drop_count", d), 64'(dc), 64'(0));
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NP; p++) mq[d][p].delete();
      exp_dv[d] = 1'b0;
      exp_dp[d] = '0;
      exp_dc[d] = '0;
    end
  endtask

  task automatic check_both_reset();
    check_reset(0, bus0.head_valid, bus0.head_rank, bus0.head_ptr, bus0.occupancy,
                bus0.drop_valid, bus0.drop_ptr, bus0.drop_count);
    check_reset(1, bus1.head_valid, bus1.head_rank, bus1.head_ptr, bus1.occupancy,
                bus1.drop_valid, bus1.drop_ptr, bus1.drop_count);
  endtask

  task automatic step(input logic en, input logic [PTW-1:0] port, input logic [RW-1:0] rank,
                      input logic [PW-1:0] ptr, input logic [NP-1:0] pop);
    @(negedge clk);
    drive(en, port, rank, ptr, pop);
    @(posedge clk);
    #1;
    model_step(0, en, port, rank, ptr, pop);
    model_step(1, en, port, rank, ptr, pop);
    check_all(0, bus0.head_valid, bus0.head_rank, bus0.head_ptr, bus0.occupancy,
              bus0.drop_valid, bus0.drop_ptr, bus0.drop_count);
    check_all(1, bus1.head_valid, bus1.head_rank, bus1.head_ptr, bus1.occupancy,
              bus1.drop_valid, bus1.drop_ptr, bus1.drop_count);
  endtask

  task automatic push(input logic [PTW-1:0] port, input logic [RW-1:0] rank,
                      input logic [PW-1:0] ptr);
    step(1'b1, port, rank, ptr, '0);
  endtask

  task automatic pop_only(input logic [NP-1:0] pop);
    step(1'b0, '0, '0, '0, pop);
  endtask

  initial begin
    clear_model();
    drive(1'b0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check_both_reset();
    @(negedge clk);
    rst = 1'b0;

    // Single-entry round trip
    push(3'd0, 19'd100, 12'h001);
    pop_only(5'b00001);
    // Ordering and equal-rank FIFO order
    push(3'd0, 19'd50, 12'h004);
    push(3'd0, 19'd10, 12'h005);
    pop_only(5'b00001);
    pop_only(5'b00001);
    push(3'd0, 19'd20, 12'h00A);
    push(3'd0, 19'd20, 12'h00B);
    pop_only(5'b00001);
    pop_only(5'b00001);
    // Simultaneous push and pop
    push(3'd0, 19'd50, 12'h006);
    step(1'b1, 3'd0, 19'd10, 12'h007, 5'b00001);
    pop_only(5'b00001);
    // Push to an empty port with a pop on that port
    step(1'b1, 3'd2, 19'd9, 12'h0C1, 5'b00100);
    pop_only(5'b00100);
    // Full port: tail-drop vs push-out, then a worse-ranked arrival
    push(3'd0, 19'd10, 12'h011);
    push(3'd0, 19'd20, 12'h012);
    push(3'd0, 19'd30, 12'h013);
    push(3'd0, 19'd40, 12'h014);
    push(3'd0, 19'd5,  12'h099);
    push(3'd0, 19'd50, 12'h098);
    // Full port with a same-cycle pop: no drop
    step(1'b1, 3'd0, 19'd1, 12'h0AA, 5'b00001);
    repeat (4) pop_only(5'b00001);
    // Port independence
    push(3'd0, 19'd7, 12'h021);
    push(3'd3, 19'd8, 12'h022);
    pop_only(5'b01001);
    // Out-of-range port
    push(3'd7, 19'd3, 12'h0EE);

    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0) ? 3'd7 : PTW'($urandom_range(0, NP - 1)),
           RW'($urandom_range(0, 15)), PW'($urandom), NP'($urandom & $urandom));
    end

    // Reset asserted mid-operation
    push(3'd1, 19'd4, 12'h031);
    push(3'd1, 19'd2, 12'h032);
    push(3'd2, 19'd6, 12'h033);
    @(negedge clk);
    drive(1'b0, '0, '0, '0, '0);
    #2 rst = 1'b1;
    #1;
    check_both_reset();
    clear_model();
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 100; k++) begin
      step(($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0) ? 3'd6 : PTW'($urandom_range(0, NP - 1)),
           RW'($urandom_range(0, 7)), PW'($urandom), NP'($urandom & $urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
